// File: rtl/morse_sequencer.sv
// Morse pattern player: latches a dot/dash pattern on a load_i falling edge and plays it on led_o.
// Define MORSE_SEQ_REPEAT_EN to add repeat_i and a 7-unit inter-word gap for continuous playback.
module morse_sequencer #(
  parameter int unsigned UNIT_TICKS = 25000000,
  parameter int unsigned MAX_LEN    = 5,
  parameter int unsigned DASH_UNITS = 3,
  parameter int unsigned GAP_UNITS  = 1,
  parameter int unsigned SIZE_W     = $clog2(MAX_LEN + 1)
) (
  input  logic               CLOCK_50,
  input  logic               rst,
  input  logic               load_i,
  input  logic [MAX_LEN-1:0] pattern_i,
  input  logic [SIZE_W-1:0]  size_i,
`ifdef MORSE_SEQ_REPEAT_EN
  input  logic               repeat_i,
`endif
  output logic               led_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [1:0]         state_o,
  output logic [SIZE_W-1:0]  sym_idx_o
);

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StMark   = 2'b01,
    StSpace  = 2'b10,
    StFinish = 2'b11
  } state_e;

  localparam int unsigned MaxDg    = (DASH_UNITS > GAP_UNITS) ? DASH_UNITS : GAP_UNITS;
  localparam int unsigned MaxUnits = (MaxDg > 7) ? MaxDg : 7;
  localparam int unsigned PW       = $clog2(UNIT_TICKS);
  localparam int unsigned UW       = $clog2(MaxUnits);

  localparam logic [PW-1:0] TickLast = PW'(UNIT_TICKS - 1);
  localparam logic [UW-1:0] DashLast = UW'(DASH_UNITS - 1);
  localparam logic [UW-1:0] GapLast  = UW'(GAP_UNITS - 1);
`ifdef MORSE_SEQ_REPEAT_EN
  localparam logic [UW-1:0] WgapLast = UW'(7 - 1);
`endif

  state_e              state;
  logic [PW-1:0]       presc;
  logic [UW-1:0]       unit_cnt;
  logic [MAX_LEN-1:0]  pat;
  logic [SIZE_W-1:0]   len;
  logic [SIZE_W-1:0]   sym_idx;
  logic [SIZE_W-1:0]   size_clamp;
  logic [UW-1:0]       mark_last;
  logic                load_prev;
  logic                load_edge;
  logic                tick;
  logic                busy;
`ifdef MORSE_SEQ_REPEAT_EN
  logic                wgap;

  // The word gap shares the idle encoding but still counts as busy.
  assign busy = (state != StIdle) || wgap;
`else
  assign busy = (state != StIdle);
`endif

  assign load_edge  = load_prev & ~load_i;
  assign tick       = (presc == TickLast);
  assign size_clamp = (size_i > SIZE_W'(MAX_LEN)) ? SIZE_W'(MAX_LEN) : size_i;

  always_comb begin
    mark_last = '0;
    if (pat[sym_idx]) mark_last = DashLast;
  end

  // Later assignments to presc/unit_cnt override the free count on a state change.
  always_ff @(posedge CLOCK_50 or negedge rst) begin
    if (!rst) begin
      state     <= StIdle;
      presc     <= '0;
      unit_cnt  <= '0;
      pat       <= '0;
      len       <= '0;
      sym_idx   <= '0;
      load_prev <= 1'b1;
`ifdef MORSE_SEQ_REPEAT_EN
      wgap      <= 1'b0;
`endif
    end else begin
      load_prev <= load_i;
      if (busy) begin
        if (tick) begin
          presc    <= '0;
          unit_cnt <= unit_cnt + 1'b1;
        end else begin
          presc <= presc + 1'b1;
        end
      end
      unique case (state)
        StIdle: begin
          if (load_edge && (size_i != '0)) begin
            pat      <= pattern_i;
            len      <= size_clamp;
            sym_idx  <= size_clamp - 1'b1;
            state    <= StMark;
            presc    <= '0;
            unit_cnt <= '0;
`ifdef MORSE_SEQ_REPEAT_EN
            wgap     <= 1'b0;
          end else if (wgap && tick && (unit_cnt == WgapLast)) begin
            wgap     <= 1'b0;
            sym_idx  <= len - 1'b1;
            state    <= StMark;
            presc    <= '0;
            unit_cnt <= '0;
`endif
          end
        end
        StMark: begin
          if (tick && (unit_cnt == mark_last)) begin
            state    <= StSpace;
            presc    <= '0;
            unit_cnt <= '0;
          end
        end
        StSpace: begin
          if (tick && (unit_cnt == GapLast)) begin
            if (sym_idx != '0) begin
              sym_idx <= sym_idx - 1'b1;
              state   <= StMark;
            end else begin
              state <= StFinish;
            end
            presc    <= '0;
            unit_cnt <= '0;
          end
        end
        StFinish: begin
          state    <= StIdle;
          sym_idx  <= '0;
          presc    <= '0;
          unit_cnt <= '0;
`ifdef MORSE_SEQ_REPEAT_EN
          wgap     <= repeat_i;
`endif
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign led_o     = (state == StMark);
  assign done_o    = (state == StFinish);
  assign busy_o    = busy;
  assign state_o   = state;
  assign sym_idx_o = sym_idx;

endmodule

// File: tb/tb_morse_sequencer.sv
// Scoreboard bench for morse_sequencer: stimulus queues expected words, a monitor checks each done_o.
module tb_morse_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_i = 1'b1;
  logic [4:0] pattern_i = '0;
  logic [2:0] size_i = '0;
  logic       led_o, busy_o, done_o;
  logic [1:0] state_o;
  logic [2:0] sym_idx_o;
`ifdef MORSE_SEQ_REPEAT_EN
  logic       repeat_i = 1'b0;
`endif

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [31:0] done_cyc;
    logic [31:0] total;
    logic [95:0] runs;
    logic [31:0] idx;
  } exp_t;

  exp_t sb[$];

  morse_sequencer #(
    .UNIT_TICKS(4),
    .MAX_LEN   (5),
    .DASH_UNITS(3),
    .GAP_UNITS (1)
  ) dut (
    .CLOCK_50 (clk),
    .rst      (rst),
    .load_i   (load_i),
    .pattern_i(pattern_i),
    .size_i   (size_i),
`ifdef MORSE_SEQ_REPEAT_EN
    .repeat_i (repeat_i),
`endif
    .led_o    (led_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .state_o  (state_o),
    .sym_idx_o(sym_idx_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] m(input int n);
    return {1'b1, n[6:0]};
  endfunction

  function automatic logic [7:0] s(input int n);
    return {1'b0, n[6:0]};
  endfunction

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int done_cyc, input int total, input logic [95:0] runs,
                          input logic [31:0] idx);
    exp_t e;
    e.done_cyc = done_cyc;
    e.total    = total;
    e.runs     = runs;
    e.idx      = idx;
    sb.push_back(e);
  endtask

  // Drives a load falling edge; base is the cycle in which load_i goes low.
  task automatic issue_load(input logic [4:0] pat, input logic [2:0] sz, input bit expect_word,
                            input int total, input logic [95:0] runs, input logic [31:0] idx,
                            input bit hold, output int base);
    @(posedge clk);
    #2;
    pattern_i = pat;
    size_i    = sz;
    load_i    = 1'b0;
    base      = cyc;
    if (expect_word) push_exp(base + total, total, runs, idx);
    if (!hold) begin
      @(posedge clk);
      #2;
      load_i = 1'b1;
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic check_quiet(input string name, input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (busy_o || led_o || done_o) bad++;
    end
    #1;
    check(name, bad, 0);
  endtask

  task automatic drain(input string name);
    int i;
    i = 0;
    while (sb.size() != 0 && i < 400) begin
      @(posedge clk);
      i++;
    end
    #2;
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: %0d words pending after %0d cycles, required 0", name, sb.size(), i);
    end
  endtask

  // Monitor: accumulates led_o run lengths and sym_idx per mark while busy, compares on done_o.
  int          acc_total = 0;
  int          nr = 0;
  int          cur_len = 0;
  logic        cur_val = 1'b0;
  logic [95:0] act_runs = '0;
  logic [31:0] act_idx = '0;
  exp_t        e_mon;

  task close_run();
    if (cur_len != 0) begin
      if (nr < 12) act_runs[95 - 8*nr -: 8] = {cur_val, 7'(cur_len)};
      nr++;
    end
  endtask

  task clear_acc();
    acc_total = 0;
    nr        = 0;
    cur_len   = 0;
    cur_val   = 1'b0;
    act_runs  = '0;
    act_idx   = '0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      clear_acc();
    end else if (busy_o) begin
      acc_total++;
      if (done_o) begin
        close_run();
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_done: got done_o=1 at cycle %0d, required 0", cyc);
        end else begin
          e_mon = sb.pop_front();
          check("done_cycle", cyc, e_mon.done_cyc);
          check("busy_cycles", acc_total, e_mon.total);
          check("led_runs", act_runs, e_mon.runs);
          check("sym_idx_seq", act_idx, e_mon.idx);
        end
        clear_acc();
      end else if (cur_len != 0 && led_o == cur_val) begin
        cur_len++;
      end else begin
        close_run();
        cur_val = led_o;
        cur_len = 1;
        if (led_o) act_idx = {act_idx[27:0], 1'b0, sym_idx_o};
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    #1;
    rst       = 1'b0;
    load_i    = 1'b0;
    pattern_i = 5'b11111;
    size_i    = 3'd0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_led", led_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_state", state_o, 0);
    check("rst_sym_idx", sym_idx_o, 0);
    rst = 1'b1;
    check_quiet("post_rst_quiet", 10);
    load_i = 1'b1;

    // dot, dash, dot; inputs change right after latching
    issue_load(5'b00010, 3'd3, 1'b1, 33, {m(4), s(4), m(12), s(4), m(4), s(4), 48'd0},
               32'h210, 1'b0, base);
    pattern_i = 5'b11111;
    size_i    = 3'd5;
    drain("word_dot_dash_dot");

    issue_load(5'b11111, 3'd0, 1'b0, 0, '0, '0, 1'b0, base);
    check_quiet("size0_quiet", 10);

    // size above MAX_LEN clamps to 5 dashes
    issue_load(5'b11111, 3'd7, 1'b1, 81,
               {m(12), s(4), m(12), s(4), m(12), s(4), m(12), s(4), m(12), s(4), 16'd0},
               32'h43210, 1'b0, base);
    drain("word_clamped");

    // second edge during MARK ignored; load held low through FINISH
    issue_load(5'b00001, 3'd2, 1'b1, 25, {m(4), s(4), m(12), s(4), 64'd0}, 32'h10, 1'b1, base);
    wait_cyc(base + 2);
    load_i = 1'b1;
    wait_cyc(base + 3);
    load_i = 1'b0;
    wait_cyc(base + 26);
    check_quiet("held_low_quiet", 10);
    load_i = 1'b1;
    issue_load(5'b00001, 3'd2, 1'b1, 25, {m(4), s(4), m(12), s(4), 64'd0}, 32'h10, 1'b0, base);
    drain("word_after_hold");

    // reset in the middle of a dash
    issue_load(5'b00001, 3'd1, 1'b0, 0, '0, '0, 1'b0, base);
    wait_cyc(base + 6);
    check("pre_rst_led", led_o, 1);
    rst = 1'b0;
    #1;
    check("midrst_led", led_o, 0);
    check("midrst_state", state_o, 0);
    check("midrst_busy", busy_o, 0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    issue_load(5'b00001, 3'd1, 1'b1, 17, {m(12), s(4), 80'd0}, 32'h0, 1'b0, base);
    drain("word_after_rst");

`ifdef MORSE_SEQ_REPEAT_EN
    repeat_i = 1'b1;
    issue_load(5'b00000, 3'd1, 1'b1, 9, {m(4), s(4), 80'd0}, 32'h0, 1'b0, base);
    push_exp(base + 46, 37, {s(28), m(4), s(4), 72'd0}, 32'h0);
    push_exp(base + 83, 37, {s(28), m(4), s(4), 72'd0}, 32'h0);
    wait_cyc(base + 50);
    repeat_i = 1'b0;
    drain("repeat_words");
    check_quiet("repeat_stop_quiet", 10);
`endif

    repeat (5) @(posedge clk);
    #2;
    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
